// File: rtl/rcv_frame_ctrl.sv
// rtl/rcv_frame_ctrl.sv - receive framing controller; define RCV_PARITY_EN to add the even-parity check state
module rcv_frame_ctrl #(
    parameter int DATA_BITS  = 8,
    parameter int BIT_PERIOD = 10
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic [DATA_BITS-1:0] sr_data,
    input  logic                 data_read,
    output logic                 serial_sync,
    output logic                 shift_strobe,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 data_ready,
    output logic                 overrun_error,
    output logic                 framing_error,
    output logic                 parity_error,
    output logic                 busy
);

    localparam int TW = $clog2(BIT_PERIOD);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] T_LAST = TW'(BIT_PERIOD - 1);
    localparam logic [TW-1:0] T_HALF = TW'(BIT_PERIOD / 2 - 1);
    localparam logic [CW-1:0] C_LAST = CW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START_CHK,
        DATA,
`ifdef RCV_PARITY_EN
        PAR_CHK,
`endif
        STOP_CHK,
        LOAD
    } state_t;

    state_t          state, state_nxt;
    logic            sync_1, sync_hist;
    logic [TW-1:0]   timer;
    logic [CW-1:0]   bit_cnt;
    logic            start_edge, timer_wrap, timer_clr;
    logic            frame_start, do_load, stop_fail, par_fail;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_1      <= 1'b1;
            serial_sync <= 1'b1;
            sync_hist   <= 1'b1;
        end else begin
            sync_1      <= serial_in;
            serial_sync <= sync_1;
            sync_hist   <= serial_sync;
        end
    end

    assign start_edge = sync_hist & ~serial_sync;
    assign timer_wrap = (timer == T_LAST);

`ifdef RCV_PARITY_EN
    assign par_fail = (state == PAR_CHK) && timer_wrap && ((^sr_data) ^ serial_sync);
`else
    assign par_fail = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (start_edge) state_nxt = START_CHK;
            START_CHK: if (timer == T_HALF) state_nxt = serial_sync ? IDLE : DATA;
            DATA: begin
                if (timer_wrap && bit_cnt == C_LAST) begin
`ifdef RCV_PARITY_EN
                    state_nxt = PAR_CHK;
`else
                    state_nxt = STOP_CHK;
`endif
                end
            end
`ifdef RCV_PARITY_EN
            PAR_CHK:   if (timer_wrap) state_nxt = par_fail ? IDLE : STOP_CHK;
`endif
            STOP_CHK:  if (timer_wrap) state_nxt = serial_sync ? LOAD : IDLE;
            LOAD:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_comb begin
        shift_strobe = (state == DATA) && timer_wrap;
        busy         = (state != IDLE);
        // Timer restarts so START_CHK counts to mid start bit and DATA to mid data bit.
        timer_clr    = (state != state_nxt) && (state_nxt == START_CHK || state_nxt == DATA);
        frame_start  = (state == IDLE) && start_edge;
        do_load      = (state == LOAD);
        stop_fail    = (state == STOP_CHK) && timer_wrap && !serial_sync;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timer   <= '0;
            bit_cnt <= '0;
        end else begin
            if (timer_clr || timer_wrap) timer <= '0;
            else                         timer <= timer + 1'b1;
            if (timer_clr)         bit_cnt <= '0;
            else if (shift_strobe) bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // A load in the same cycle as data_read wins: the new word stays ready, no overrun.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rx_data       <= '0;
            data_ready    <= 1'b0;
            overrun_error <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            if (do_load) begin
                rx_data       <= sr_data;
                data_ready    <= 1'b1;
                overrun_error <= data_ready & ~data_read;
            end else if (data_read) begin
                data_ready    <= 1'b0;
                overrun_error <= 1'b0;
            end
            if (frame_start)    framing_error <= 1'b0;
            else if (stop_fail) framing_error <= 1'b1;
        end
    end

`ifdef RCV_PARITY_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst)           parity_error <= 1'b0;
        else if (frame_start) parity_error <= 1'b0;
        else if (par_fail)    parity_error <= 1'b1;
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule
